// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: steps a PWM channel's on-time toward a target, one step per N period boundaries
module pwm_ramp_ctrl #(
   parameter int W  = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          period_tick,
   input  logic [W-1:0]  t_period,
   input  logic          target_load,
   input  logic [W-1:0]  target_t_on,
   input  logic [W-1:0]  step,
   input  logic [CW-1:0] interval,
   output logic [W-1:0]  t_on_out,
   output logic          update,
   output logic          busy,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, WAIT, STEP} state_t;
   state_t        r_state, w_state_nxt;
   logic [W-1:0]  r_tgt, r_stp, r_t_on, w_tgt_nxt, w_stp_nxt, w_t_on_nxt, w_stepped, w_load_tgt;
   logic [CW-1:0] r_ivl, r_cnt, w_ivl_nxt, w_cnt_nxt, w_load_ivl;
   logic          r_update, r_done, w_update_nxt, w_done_nxt;
   logic [W:0]    w_sum, w_dif;
   // one extra bit keeps the step arithmetic free of wrap-around and underflow
   assign w_sum      = {1'b0, r_t_on} + {1'b0, r_stp};
   assign w_dif      = {1'b0, r_t_on} - {1'b0, r_stp};
   assign w_load_tgt = (target_t_on < t_period) ? target_t_on : t_period;
   assign w_load_ivl = (interval == '0) ? CW'(1) : interval;
   assign w_stepped  = (r_t_on < r_tgt)
                     ? ((r_stp == '0 || w_sum >= {1'b0, r_tgt}) ? r_tgt : w_sum[W-1:0])
                     : ((r_stp == '0 || w_dif[W] || w_dif[W-1:0] <= r_tgt) ? r_tgt : w_dif[W-1:0]);
   assign t_on_out   = r_t_on;
   assign update     = r_update;
   assign done       = r_done;
   assign busy       = (r_state != IDLE);
   // next-state logic: a pending step completes first, then a new load overrides target and counter
   always_comb begin
      w_state_nxt  = r_state;
      w_t_on_nxt   = r_t_on;
      w_tgt_nxt    = r_tgt;
      w_stp_nxt    = r_stp;
      w_ivl_nxt    = r_ivl;
      w_cnt_nxt    = r_cnt;
      w_update_nxt = 1'b0;
      w_done_nxt   = 1'b0;
      if (!enable) begin
         w_state_nxt = IDLE;
      end else begin
         if (r_state == STEP) begin
            w_t_on_nxt   = w_stepped;
            w_update_nxt = 1'b1;
            w_done_nxt   = (w_stepped == r_tgt);
            w_state_nxt  = w_done_nxt ? IDLE : WAIT;
         end
         if (target_load) begin
            w_tgt_nxt   = w_load_tgt;
            w_stp_nxt   = step;
            w_ivl_nxt   = w_load_ivl;
            w_cnt_nxt   = w_load_ivl;
            w_done_nxt  = (w_load_tgt == w_t_on_nxt);
            w_state_nxt = w_done_nxt ? IDLE : WAIT;
         end else if (r_state == WAIT && period_tick) begin
            w_state_nxt = (r_cnt == CW'(1)) ? STEP : WAIT;
            w_cnt_nxt   = (r_cnt == CW'(1)) ? r_ivl : r_cnt - CW'(1);
         end
      end
   end
   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_t_on   <= '0;
         r_tgt    <= '0;
         r_stp    <= '0;
         r_ivl    <= '0;
         r_cnt    <= '0;
         r_update <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_t_on   <= w_t_on_nxt;
         r_tgt    <= w_tgt_nxt;
         r_stp    <= w_stp_nxt;
         r_ivl    <= w_ivl_nxt;
         r_cnt    <= w_cnt_nxt;
         r_update <= w_update_nxt;
         r_done   <= w_done_nxt;
      end
   end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed and randomized checks of pwm_ramp_ctrl against a ramp reference model
module tb_pwm_ramp_ctrl;
   localparam int W  = 32;
   localparam int CW = 16;
   logic          clk = 1'b0, reset = 1'b0, enable = 1'b0, period_tick = 1'b0, target_load = 1'b0;
   logic [W-1:0]  t_period = '0, target_t_on = '0, step = '0;
   logic [CW-1:0] interval = '0;
   logic [W-1:0]  t_on_out;
   logic          update, busy, done;
   int            n_cmp = 0, n_err = 0;

   pwm_ramp_ctrl #(.W(W), .CW(CW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .period_tick(period_tick),
      .t_period(t_period), .target_load(target_load), .target_t_on(target_t_on),
      .step(step), .interval(interval), .t_on_out(t_on_out), .update(update),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // reference model: on-time, target, ticks remaining until the next step, and a pending-step flag
   logic [W-1:0]  m_t_on, m_tgt, m_stp, n_t_on, n_tgt, n_stp;
   logic [CW-1:0] m_ivl, m_left, n_ivl, n_left;
   logic          m_busy, m_step, m_upd, m_done, n_busy, n_step, n_upd, n_done;

   function automatic logic [W-1:0] ramp(input logic [W-1:0] cur, input logic [W-1:0] tgt, input logic [W-1:0] s);
      longint c = longint'(cur), t = longint'(tgt), d = longint'(s);
      if (d == 0) return tgt;
      if (c < t) return (c + d >= t) ? tgt : W'(c + d);
      return (c - d <= t) ? tgt : W'(c - d);
   endfunction

   always_comb begin
      n_t_on = m_t_on; n_tgt = m_tgt; n_stp = m_stp; n_ivl = m_ivl; n_left = m_left;
      n_busy = m_busy; n_step = 1'b0; n_upd = 1'b0; n_done = 1'b0;
      if (!enable) begin
         n_busy = 1'b0;
      end else begin
         if (m_step) begin
            n_t_on = ramp(m_t_on, m_tgt, m_stp);
            n_upd  = 1'b1;
            n_done = (n_t_on == m_tgt);
            n_busy = !n_done;
         end
         if (target_load) begin
            n_tgt  = (target_t_on > t_period) ? t_period : target_t_on;
            n_stp  = step;
            n_ivl  = (interval == 0) ? CW'(1) : interval;
            n_left = n_ivl;
            n_done = (n_tgt == n_t_on);
            n_busy = !n_done;
         end else if (period_tick && m_busy && !m_step) begin
            if (m_left == 1) begin
               n_step = 1'b1;
               n_left = m_ivl;
            end else begin
               n_left = m_left - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_t_on <= '0; m_tgt <= '0; m_stp <= '0; m_ivl <= '0; m_left <= '0;
         m_busy <= 1'b0; m_step <= 1'b0; m_upd <= 1'b0; m_done <= 1'b0;
      end else begin
         m_t_on <= n_t_on; m_tgt <= n_tgt; m_stp <= n_stp; m_ivl <= n_ivl; m_left <= n_left;
         m_busy <= n_busy; m_step <= n_step; m_upd <= n_upd; m_done <= n_done;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("model t_on_out", 64'(t_on_out), 64'(m_t_on));
      chk("model update", 64'(update), 64'(m_upd));
      chk("model busy", 64'(busy), 64'(m_busy));
      chk("model done", 64'(done), 64'(m_done));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         check_model();
      end
   endtask

   task automatic load(input logic [W-1:0] t, input logic [W-1:0] s, input logic [CW-1:0] i);
      target_t_on = t; step = s; interval = i; target_load = 1'b1;
      cyc(1);
      target_load = 1'b0;
   endtask

   // one period tick followed by the cycle in which any resulting step lands on the outputs
   task automatic tick();
      period_tick = 1'b1;
      cyc(1);
      period_tick = 1'b0;
      cyc(1);
   endtask

   initial begin
      cyc(2);
      @(negedge clk);
      reset = 1'b1;
      cyc(1);
      chk("reset t_on_out", 64'(t_on_out), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      enable = 1'b1; t_period = 32'd1000;
      cyc(1);
      // rising ramp, ticks twenty cycles apart
      load(32'd250, 32'd100, 16'd2);
      chk("rise busy after load", 64'(busy), 64'd1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 2) chk("rise after tick 2", 64'(t_on_out), 64'd100);
         if (k == 4) chk("rise after tick 4", 64'(t_on_out), 64'd200);
         if (k == 6) begin
            chk("rise final value", 64'(t_on_out), 64'd250);
            chk("rise final update", 64'(update), 64'd1);
            chk("rise final done", 64'(done), 64'd1);
            chk("rise busy cleared", 64'(busy), 64'd0);
         end
         cyc(18);
      end
      // falling ramp with saturation at the target
      load(32'd5, 32'd100, 16'd1);
      tick(); chk("fall 150", 64'(t_on_out), 64'd150);
      tick(); chk("fall 50", 64'(t_on_out), 64'd50);
      tick(); chk("fall saturates 5", 64'(t_on_out), 64'd5);
      chk("fall done", 64'(done), 64'd1);
      // clamp to period with step 0
      load(32'd2000, 32'd0, 16'd1);
      tick(); chk("clamp jump", 64'(t_on_out), 64'd1000);
      chk("clamp done", 64'(done), 64'd1);
      // equal target
      load(32'd500, 32'd0, 16'd0);
      tick(); chk("equal setup", 64'(t_on_out), 64'd500);
      cyc(2);
      load(32'd500, 32'd0, 16'd1);
      chk("equal done", 64'(done), 64'd1);
      chk("equal busy", 64'(busy), 64'd0);
      chk("equal update", 64'(update), 64'd0);
      cyc(1);
      chk("equal done single", 64'(done), 64'd0);
      // load coincident with a tick restarts the interval count
      load(32'd700, 32'd100, 16'd2);
      tick();
      target_t_on = 32'd800; step = 32'd100; interval = 16'd2;
      target_load = 1'b1; period_tick = 1'b1;
      cyc(1);
      target_load = 1'b0; period_tick = 1'b0;
      cyc(1);
      tick();
      chk("collision tick ignored", 64'(t_on_out), 64'd500);
      chk("collision no update", 64'(update), 64'd0);
      tick();
      chk("collision step", 64'(t_on_out), 64'd600);
      // mid-ramp reversal
      load(32'd100, 32'd100, 16'd1);
      tick(); chk("reverse", 64'(t_on_out), 64'd500);
      tick(); tick(); tick();
      chk("reverse to 200", 64'(t_on_out), 64'd200);
      // abort via enable
      enable = 1'b0;
      cyc(1);
      chk("abort busy", 64'(busy), 64'd0);
      tick(); tick();
      load(32'd900, 32'd100, 16'd1);
      tick();
      chk("abort holds", 64'(t_on_out), 64'd200);
      chk("abort busy stays low", 64'(busy), 64'd0);
      enable = 1'b1;
      cyc(1);
      // asynchronous reset mid-ramp
      load(32'd900, 32'd100, 16'd1);
      tick();
      chk("pre-reset value", 64'(t_on_out), 64'd300);
      chk("pre-reset busy", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("async reset t_on_out", 64'(t_on_out), 64'd0);
      chk("async reset busy", 64'(busy), 64'd0);
      chk("async reset update", 64'(update), 64'd0);
      chk("async reset done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      cyc(2);
      // no wrap-around near the top of the range
      t_period = 32'hFFFF_FFFF;
      load(32'hFFFF_FF00, 32'd0, 16'd1);
      tick(); chk("overflow setup", 64'(t_on_out), 64'hFFFF_FF00);
      load(32'hFFFF_FFFF, 32'h200, 16'd1);
      tick(); chk("overflow saturates", 64'(t_on_out), 64'hFFFF_FFFF);
      chk("overflow done", 64'(done), 64'd1);
      // randomized traffic against the model
      t_period = 32'd1000;
      for (int i = 0; i < 2500; i++) begin
         target_load = ($urandom_range(0, 19) == 0);
         target_t_on = $urandom_range(0, 1200);
         step        = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
         interval    = 16'($urandom_range(0, 3));
         period_tick = ($urandom_range(0, 2) == 0);
         enable      = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 99) == 0) t_period = $urandom_range(400, 1100);
         cyc(1);
      end
      target_load = 1'b0; period_tick = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
